// File: rtl/shifter_seq_if.sv
// Start/busy/done handshake bundle for the multi-cycle shifter.
// The master issues operations and the slave returns the result.
interface shifter_seq_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             Start;
  logic [WIDTH-1:0] In;
  logic [CNT_W-1:0] Cnt;
  logic [2:0]       Op;
  logic [WIDTH-1:0] Out;
  logic             Busy;
  logic             Done;

  modport master (
    output Start,
    output In,
    output Cnt,
    output Op,
    input  Out,
    input  Busy,
    input  Done
  );

  modport slave (
    input  Start,
    input  In,
    input  Cnt,
    input  Op,
    output Out,
    output Busy,
    output Done
  );
endinterface

// File: rtl/shifter_seq.sv
// Multi-cycle shifter/rotator: one bit position per clock.
// Supports ROL, SLL, SRA, SRL and ROR with a start/busy/done handshake.
module shifter_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  shifter_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  state_t           state;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] rem;
  logic [2:0]       op_q;
  logic             busy_q;
  logic             done_q;

  function automatic logic [WIDTH-1:0] shift1(
    input logic [WIDTH-1:0] v,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      OP_ROR:  r = {v[0], v[WIDTH-1:1]};
      // Reserved codes hold the operand but still burn Cnt cycles.
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      out_q  <= '0;
      rem    <= '0;
      op_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.Start) begin
            out_q <= bus.In;
            rem   <= bus.Cnt;
            op_q  <= bus.Op;
            if (bus.Cnt == '0) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state  <= SHIFT;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        SHIFT: begin
          out_q <= shift1(out_q, op_q);
          rem   <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Out  = out_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Directed bench for shifter_seq with a timeline-based reference model.
// Every cycle compares Busy/Done/Out against the model; directed literals pin it.
module tb_shifter_seq;
  localparam int W  = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shifter_seq_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  shifter_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  bit          armed = 1'b0;
  int          m_lo  = 0;
  int          m_hi  = -1;
  int          m_dn  = -1;
  logic [15:0] m_res = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [2:0] op,
                                         input logic [15:0] v,
                                         input int n);
    logic [31:0]        x;
    logic signed [15:0] s;
    x = {16'h0, v};
    s = v;
    case (op)
      3'd0:    return 16'((x << n) | (x >> (16 - n)));
      3'd1:    return 16'(x << n);
      3'd2:    return 16'(s >>> n);
      3'd3:    return 16'(x >> n);
      3'd4:    return 16'((x >> n) | (x << (16 - n)));
      default: return v;
    endcase
  endfunction

  // Model: an accepted start at the edge ending cycle e occupies
  // cycles e+1..e+N busy, then Done in e+N+1.
  always @(posedge clk) begin
    int n;
    n = cyc + 1;
    if (rst) begin
      armed = 1'b1;
      m_lo  = 0;
      m_hi  = -1;
      m_dn  = -1;
      m_res = '0;
    end else if (armed && bus.Start && !(cyc >= m_lo && cyc <= m_hi)) begin
      m_lo  = n;
      m_hi  = n + int'(bus.Cnt) - 1;
      m_dn  = n + int'(bus.Cnt);
      m_res = ref_op(bus.Op, bus.In, int'(bus.Cnt));
    end
    cyc = n;
  end

  always @(negedge clk) begin
    bit eb;
    if (armed) begin
      eb = (cyc >= m_lo) && (cyc <= m_hi);
      chk("busy", 32'(bus.Busy), 32'(eb));
      chk("done", 32'(bus.Done), 32'(cyc == m_dn));
      if (!eb) chk("out", 32'(bus.Out), 32'(m_res));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [15:0] v,
                          input logic [3:0] c, output int t);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.In    = v;
    bus.Cnt   = c;
    t = cyc;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(output int td);
    td = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        td = cyc;
        break;
      end
    end
    if (td < 0) begin
      nvec++;
      nerr++;
      $display("FAIL done_timeout @cyc %0d: got none, want Done", cyc);
    end
  endtask

  task automatic run(input string name, input logic [2:0] op,
                     input logic [15:0] v, input logic [3:0] c,
                     input logic [15:0] exp);
    int t;
    int td;
    start_op(op, v, c, t);
    wait_done(td);
    chk({name, "_lat"}, 32'(td), 32'(t + int'(c) + 1));
    chk({name, "_out"}, 32'(bus.Out), 32'(exp));
    tick();
  endtask

  initial begin
    int t;
    int td;
    int ndone;
    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.In    = '0;
    bus.Cnt   = '0;
    bus.Op    = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out", 32'(bus.Out), 32'h0);
    chk("rst_busy", 32'(bus.Busy), 32'h0);
    chk("rst_done", 32'(bus.Done), 32'h0);
    tick();

    run("rol", 3'd0, 16'h8001, 4'd1, 16'h0003);
    run("sra", 3'd2, 16'h8000, 4'd15, 16'hFFFF);
    run("srl", 3'd3, 16'h8000, 4'd15, 16'h0001);
    run("sll", 3'd1, 16'h00FF, 4'd8, 16'hFF00);
    run("ror", 3'd4, 16'h0001, 4'd4, 16'h1000);
    run("cnt0", 3'd1, 16'h1234, 4'd0, 16'h1234);
    run("rsv", 3'd5, 16'hABCD, 4'd3, 16'hABCD);
    run("ror15", 3'd4, 16'h8001, 4'd15, 16'h0003);

    // Start re-pulsed mid-shift must be ignored.
    start_op(3'd0, 16'h0003, 4'd5, t);
    tick();
    bus.Start = 1'b1;
    bus.In    = 16'hFFFF;
    bus.Op    = 3'd1;
    bus.Cnt   = 4'd1;
    tick();
    bus.Start = 1'b0;
    wait_done(td);
    chk("ign_lat", 32'(td), 32'(t + 6));
    chk("ign_out", 32'(bus.Out), 32'h0060);
    tick();

    // Start held in the DONE cycle chains a second operation.
    start_op(3'd1, 16'h0001, 4'd2, t);
    tick();
    tick();
    bus.Start = 1'b1;
    bus.Op    = 3'd4;
    bus.In    = 16'h0002;
    bus.Cnt   = 4'd1;
    @(negedge clk);
    chk("b2b_done1", 32'(bus.Done), 32'h1);
    chk("b2b_out1", 32'(bus.Out), 32'h0004);
    tick();
    bus.Start = 1'b0;
    wait_done(td);
    chk("b2b_lat2", 32'(td), 32'(t + 5));
    chk("b2b_out2", 32'(bus.Out), 32'h0001);
    tick();

    // Reset mid-operation aborts with no Done.
    start_op(3'd3, 16'h8000, 4'd10, t);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out", 32'(bus.Out), 32'h0);
    chk("abort_busy", 32'(bus.Busy), 32'h0);
    chk("abort_done", 32'(bus.Done), 32'h0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.Done) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 32'h0);
    tick();
    run("post_rst", 3'd0, 16'h0001, 4'd2, 16'h0004);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/shifter_seq.md
Name: shifter_seq

Overview:
- Parametrised multi-cycle shifter/rotator for the datapath. It shifts by one bit per clock, up to WIDTH-1 positions.
- Adds rotate-right and a start/busy/done handshake.
- Used where a full barrel shifter is too costly, e.g. multi-cycle shift/rotate instructions in the execute stage.
- The result is held in an internal register until the next accepted Start.

Parameters:
- WIDTH, 16, data width in bits. Must equal 2**CNT_W.
- CNT_W, 4, width of the shift-amount field.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- Start  input  1  request a new operation. Sampled only when the block is not shifting.
- In  input  WIDTH  operand; captured on an accepted Start.
- Cnt  input  CNT_W  shift amount 0..WIDTH-1; captured on an accepted Start.
- Op  input  3  operation; captured on an accepted Start.
  - 000 ROL
  - 001 SLL
  - 010 SRA
  - 011 SRL
  - 100 ROR
  - 101..111 reserved
- Out  output  WIDTH  working/result register.
- Busy  output  1  high while shifting.
- Done  output  1  one-cycle pulse; Out holds the final result.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, Out=0, Busy=0, Done=0, internal count=0.
  - Reset overrides Start.
  - Reset mid-operation aborts the operation; no Done is produced for it.
- States: IDLE, SHIFT, DONE.
  - Busy=1 only in SHIFT.
  - Done=1 only in DONE.
- Start acceptance:
  - Start is accepted in IDLE or DONE; this allows back-to-back operations.
  - On acceptance: Out<=In, rem<=Cnt, op register<=Op.
  - Next state is DONE if Cnt==0, else SHIFT.
- Start in SHIFT is ignored. No queuing; In, Cnt and Op changes are invisible to the running operation.
- SHIFT, each edge: Out<=shift1(Out, op), rem<=rem-1. If rem==1, next state is DONE.
- DONE: lasts one cycle, then IDLE unless Start is accepted in that cycle.
- Latency: Start sampled in cycle t with Cnt=N gives Busy high in cycles t+1..t+N and Done high in cycle t+N+1.
- Out is stable from Done until the next accepted Start. Intermediate values are visible during SHIFT and carry no meaning.
- shift1 definitions (W=WIDTH):
  - ROL: {Out[W-2:0], Out[W-1]}
  - SLL: {Out[W-2:0], 1'b0}
  - SRA: {Out[W-1], Out[W-1:1]}
  - SRL: {1'b0, Out[W-1:1]}
  - ROR: {Out[0], Out[W-1:1]}
  - Reserved Op: identity (Out unchanged). Timing still follows Cnt, so Done comes at t+Cnt+1.
- Cnt range: Cnt=0 is legal and gives Out=In. Cnt wider than WIDTH-1 cannot occur because WIDTH=2**CNT_W.
- Sign handling: SRA repeats the original sign bit on every step. Shifting 0x8000 right-arithmetic by 15 gives 0xFFFF.
- Out is a register output only; no combinational path from inputs to outputs.

Test Plan (WIDTH=16; Start pulsed for one cycle at cycle t):
- ROL, In=0x8001, Cnt=1:
  - Busy at t+1.
  - Done at t+2 with Out=0x0003.
- SRA, In=0x8000, Cnt=15:
  - Busy for 15 cycles.
  - Done at t+16 with Out=0xFFFF.
- SRL, same In and Cnt:
  - Out=0x0001.
- SLL, In=0x00FF, Cnt=8:
  - Out=0xFF00 at t+9.
- ROR, In=0x0001, Cnt=4:
  - Out=0x1000 at t+5.
- Cnt=0 with Op=001, In=0x1234:
  - Busy never asserts.
  - Done at t+1 with Out=0x1234.
- Reserved Op=101, In=0xABCD, Cnt=3:
  - Done at t+4 with Out=0xABCD.
- Start re-pulsed with new In during SHIFT:
  - Ignored; the original result and timing are unchanged.
- Start held during the DONE cycle:
  - New operation accepted.
  - Done of the first op still pulses exactly once.
- rst=1 at t+3 during SRL Cnt=10:
  - Next cycle: Out=0x0000, Busy=0, Done=0.
  - No Done appears later.
  - A following ROL, In=0x0001, Cnt=2 yields 0x0004 at the expected latency.
